// File: rtl/led_pwm_driver.sv
// rtl/led_pwm_driver.sv - PWM/blink output stage for a 24-bit LED register, three 8-LED groups
// Settings are double-buffered and only become active on PWM period boundaries.
module led_pwm_driver #(
  parameter int PRESCALE      = 100,
  parameter int PWM_BITS      = 4,
  parameter int BLINK_PERIODS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] led_in,
  input  logic        cfg_write,
  input  logic [1:0]  cfg_sel,
  input  logic [15:0] cfg_wdata,
  output logic [23:0] led_pin,
  output logic        period_start
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int BC_W = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
  localparam int BR_W = 3 * PWM_BITS;

  localparam logic [PS_W-1:0]     PS_MAX  = PS_W'(PRESCALE - 1);
  localparam logic [BC_W-1:0]     BC_MAX  = BC_W'(BLINK_PERIODS - 1);
  localparam logic [PWM_BITS-1:0] PWM_MAX = '1;

  logic [PS_W-1:0]     prescale_q,     prescale_d;
  logic [PWM_BITS-1:0] pwm_cnt_q,      pwm_cnt_d;
  logic [BC_W-1:0]     blink_cnt_q,    blink_cnt_d;
  logic                blink_phase_q,  blink_phase_d;
  logic [BR_W-1:0]     pend_bright_q,  pend_bright_d;
  logic [23:0]         pend_blink_q,   pend_blink_d;
  logic [BR_W-1:0]     act_bright_q,   act_bright_d;
  logic [23:0]         act_blink_q,    act_blink_d;
  logic [23:0]         act_led_q,      act_led_d;
  logic [23:0]         led_pin_q,      led_pin_d;
  logic                period_start_q, period_start_d;

  logic       tick;
  logic       boundary;
  logic [2:0] group_on;

  always_comb begin
    tick     = (prescale_q == PS_MAX);
    boundary = tick && (pwm_cnt_q == PWM_MAX);

    prescale_d = tick ? '0 : prescale_q + 1'b1;
    pwm_cnt_d  = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;

    pend_bright_d = pend_bright_q;
    pend_blink_d  = pend_blink_q;
    if (cfg_write) begin
      case (cfg_sel)
        2'b00:   pend_bright_d = cfg_wdata[BR_W-1:0];
        2'b01:   pend_blink_d[15:0]  = cfg_wdata;
        2'b10:   pend_blink_d[23:16] = cfg_wdata[7:0];
        default: ;
      endcase
    end

    // Active set samples the pre-edge pending values, so a write on the boundary cycle waits a period.
    act_bright_d  = act_bright_q;
    act_blink_d   = act_blink_q;
    act_led_d     = act_led_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (boundary) begin
      act_bright_d = pend_bright_q;
      act_blink_d  = pend_blink_q;
      act_led_d    = led_in;
      if (blink_cnt_q == BC_MAX) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end

    // Full-scale brightness is forced on so the LED never dips for the last PWM step.
    for (int g = 0; g < 3; g++) begin
      group_on[g] = (act_bright_q[g*PWM_BITS +: PWM_BITS] == PWM_MAX) ||
                    (pwm_cnt_q < act_bright_q[g*PWM_BITS +: PWM_BITS]);
    end

    for (int i = 0; i < 24; i++) begin
      led_pin_d[i] = act_led_q[i] & group_on[i/8] & ~(act_blink_q[i] & blink_phase_q);
    end

    period_start_d = boundary;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prescale_q     <= '0;
      pwm_cnt_q      <= '0;
      blink_cnt_q    <= '0;
      blink_phase_q  <= 1'b0;
      pend_bright_q  <= '1;
      pend_blink_q   <= '0;
      act_bright_q   <= '1;
      act_blink_q    <= '0;
      act_led_q      <= '0;
      led_pin_q      <= '0;
      period_start_q <= 1'b0;
    end else begin
      prescale_q     <= prescale_d;
      pwm_cnt_q      <= pwm_cnt_d;
      blink_cnt_q    <= blink_cnt_d;
      blink_phase_q  <= blink_phase_d;
      pend_bright_q  <= pend_bright_d;
      pend_blink_q   <= pend_blink_d;
      act_bright_q   <= act_bright_d;
      act_blink_q    <= act_blink_d;
      act_led_q      <= act_led_d;
      led_pin_q      <= led_pin_d;
      period_start_q <= period_start_d;
    end
  end

  assign led_pin      = led_pin_q;
  assign period_start = period_start_q;

endmodule

// File: tb/tb_led_pwm_driver.sv
// tb/tb_led_pwm_driver.sv - self-checking bench for led_pwm_driver against a period-level model
module tb_led_pwm_driver;

  localparam int PRE = 2;
  localparam int PB  = 4;
  localparam int BP  = 2;
  localparam int PER = PRE << PB;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] led_in;
  logic        cfg_write;
  logic [1:0]  cfg_sel;
  logic [15:0] cfg_wdata;
  logic [23:0] led_pin;
  logic        period_start;

  int ncmp = 0;
  int nfail = 0;

  int          cyc;
  int          nb;
  logic [11:0] p_bright;
  logic [23:0] p_blink;
  logic [11:0] m_bright;
  logic [23:0] m_blink;
  logic [23:0] m_led;

  led_pwm_driver #(.PRESCALE(PRE), .PWM_BITS(PB), .BLINK_PERIODS(BP)) dut (
    .clk          (clk),
    .rst          (rst),
    .led_in       (led_in),
    .cfg_write    (cfg_write),
    .cfg_sel      (cfg_sel),
    .cfg_wdata    (cfg_wdata),
    .led_pin      (led_pin),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    cyc      = 0;
    nb       = 0;
    p_bright = 12'hFFF;
    p_blink  = '0;
    m_bright = 12'hFFF;
    m_blink  = '0;
    m_led    = '0;
  endtask

  // A group with brightness b is lit for the first b*PRE clocks of a period, or all of it at b=15.
  function automatic logic [23:0] model_pins(int pos);
    logic [23:0] r;
    int b;
    bit on;
    bit phase;
    phase = ((nb / BP) % 2) == 1;
    for (int i = 0; i < 24; i++) begin
      b  = int'(m_bright[(i/8)*PB +: PB]);
      on = (b == 15) || (pos < b * PRE);
      r[i] = m_led[i] && on && !(m_blink[i] && phase);
    end
    return r;
  endfunction

  task automatic step();
    int          pos;
    logic [23:0] e_pin;
    logic        e_ps;
    logic        w;
    logic [1:0]  s;
    logic [15:0] d;
    logic [23:0] li;
    pos   = cyc % PER;
    e_pin = model_pins(pos);
    e_ps  = (pos == PER - 1);
    w = cfg_write; s = cfg_sel; d = cfg_wdata; li = led_in;
    @(posedge clk);
    if (pos == PER - 1) begin
      m_bright = p_bright;
      m_blink  = p_blink;
      m_led    = li;
      nb++;
    end
    if (w) begin
      case (s)
        2'b00:   p_bright = d[11:0];
        2'b01:   p_blink[15:0] = d;
        2'b10:   p_blink[23:16] = d[7:0];
        default: ;
      endcase
    end
    cyc++;
    @(negedge clk);
    ncmp++;
    assert (led_pin === e_pin) else begin
      nfail++;
      $error("FAIL led_pin cyc=%0d observed=%h expected=%h", cyc, led_pin, e_pin);
    end
    ncmp++;
    assert (period_start === e_ps) else begin
      nfail++;
      $error("FAIL period_start cyc=%0d observed=%b expected=%b", cyc, period_start, e_ps);
    end
  endtask

  task automatic do_write(input logic [1:0] sel, input logic [15:0] data);
    cfg_write = 1'b1;
    cfg_sel   = sel;
    cfg_wdata = data;
    step();
    cfg_write = 1'b0;
  endtask

  task automatic run_to_boundary();
    while (cyc % PER != PER - 1) step();
    step();
  endtask

  initial begin
    int c0, c1, c2, nps;
    logic [23:0] snap;

    rst = 1'b0; led_in = '0; cfg_write = 1'b0; cfg_sel = '0; cfg_wdata = '0;
    model_reset();
    @(negedge clk); @(negedge clk);
    ncmp++;
    assert (led_pin === 24'h0) else begin
      nfail++; $error("FAIL reset_led_pin observed=%h expected=%h", led_pin, 24'h0);
    end
    ncmp++;
    assert (period_start === 1'b0) else begin
      nfail++; $error("FAIL reset_period_start observed=%b expected=%b", period_start, 1'b0);
    end

    // Register word appears one clock after the first boundary, period_start every PER clocks.
    rst = 1'b1;
    led_in = 24'hA5A5A5;
    nps = 0;
    for (int i = 0; i < 4 * PER; i++) begin
      step();
      if (period_start) nps++;
    end
    ncmp++;
    assert (nps == 4) else begin
      nfail++; $error("FAIL period_start_count observed=%0d expected=%0d", nps, 4);
    end

    // Brightness 04F: group0 full, group1 4/16, group2 off.
    led_in = 24'hFFFFFF;
    for (int i = 0; i < 5; i++) step();
    do_write(2'b00, 16'h004F);
    run_to_boundary();
    run_to_boundary();
    c0 = 0; c1 = 0; c2 = 0;
    for (int i = 0; i < PER; i++) begin
      step();
      if (led_pin[7:0] == 8'hFF) c0++;
      if (led_pin[15:8] == 8'hFF) c1++;
      if (led_pin[23:16] == 8'hFF) c2++;
    end
    ncmp++;
    assert (c0 == 32) else begin nfail++; $error("FAIL duty_g0 observed=%0d expected=%0d", c0, 32); end
    ncmp++;
    assert (c1 == 8) else begin nfail++; $error("FAIL duty_g1 observed=%0d expected=%0d", c1, 8); end
    ncmp++;
    assert (c2 == 0) else begin nfail++; $error("FAIL duty_g2 observed=%0d expected=%0d", c2, 0); end

    // Write landing on the boundary cycle must wait one full period.
    while (cyc % PER != PER - 1) step();
    do_write(2'b00, 16'h0F00);
    c0 = 0;
    for (int i = 0; i < PER; i++) begin
      step();
      if (led_pin[7:0] == 8'hFF) c0++;
    end
    ncmp++;
    assert (c0 == 32) else begin nfail++; $error("FAIL boundary_write_old observed=%0d expected=%0d", c0, 32); end
    c0 = 0;
    for (int i = 0; i < PER; i++) begin
      step();
      if (led_pin[7:0] != 8'h00) c0++;
    end
    ncmp++;
    assert (c0 == 0) else begin nfail++; $error("FAIL boundary_write_new observed=%0d expected=%0d", c0, 0); end

    // Blink on the low byte, full brightness.
    do_write(2'b00, 16'h0FFF);
    do_write(2'b01, 16'h00FF);
    led_in = 24'h0000FF;
    for (int i = 0; i < 6 * PER; i++) step();

    // Mid-period led_in change must not reach the pins before the boundary.
    while (cyc % PER != 10) step();
    snap = led_pin;
    led_in = ~led_in;
    while (cyc % PER != PER - 1) step();
    step();
    ncmp++;
    assert (led_pin === snap) else begin
      nfail++; $error("FAIL no_glitch observed=%h expected=%h", led_pin, snap);
    end
    for (int i = 0; i < 2 * PER; i++) step();

    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(7) == 0) begin
        cfg_write = 1'b1;
        cfg_sel   = 2'($urandom_range(3));
        cfg_wdata = 16'($urandom);
      end else begin
        cfg_write = 1'b0;
      end
      if ($urandom_range(15) == 0) led_in = 24'($urandom);
      step();
    end
    cfg_write = 1'b0;

    // Asynchronous reset in the middle of a period.
    led_in = 24'hFFFFFF;
    while (cyc % PER != 13) step();
    #2 rst = 1'b0;
    #1;
    ncmp++;
    assert (led_pin === 24'h0) else begin
      nfail++; $error("FAIL async_reset_pin observed=%h expected=%h", led_pin, 24'h0);
    end
    ncmp++;
    assert (period_start === 1'b0) else begin
      nfail++; $error("FAIL async_reset_ps observed=%b expected=%b", period_start, 1'b0);
    end
    @(negedge clk);
    model_reset();
    rst = 1'b1;
    nps = -1;
    for (int i = 0; i < 3 * PER; i++) begin
      step();
      if (period_start && nps < 0) nps = i + 1;
    end
    ncmp++;
    assert (nps == PER) else begin
      nfail++; $error("FAIL first_period_start observed=%0d expected=%0d", nps, PER);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
